ram_wr_sequencer: RTL and testbench
===================================

# ram_wr_sequencer

Write-port controller for the single-clock simple dual-port RAM: it owns the RAM's write port (`b_addr`/`b_we`/`b_wrdata`). After reset, or on request, it sweeps every RAM location with a fill value. It then shares the write port between two valid/ready requesters using round-robin arbitration. The RAM read port is not touched by this block; readers connect to it directly.

## Interface
- `ADDR_WIDTH`, default 16: RAM address width; the RAM holds N = 2**ADDR_WIDTH words.
- `DATA_WIDTH`, default 64: RAM word width.
- `INIT_VALUE`, default all-zero: fill value written during a sweep.
- `DO_INIT`, default 1: 1 = run a sweep out of reset; 0 = start directly in RUN.

- `clk` in 1: single clock; all state changes on its rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `init_done` out 1: high while in RUN.
- `clear_req` in 1: level request to start a new sweep.
- `w0_valid` in 1: requester 0 has a write pending.
- `w0_ready` out 1: requester 0's write is accepted this cycle.
- `w0_addr` in ADDR_WIDTH: requester 0 write address.
- `w0_data` in DATA_WIDTH: requester 0 write data.
- `w1_valid`, `w1_ready`, `w1_addr`, `w1_data`: requester 1, same widths and meanings as requester 0.
- `b_addr` out ADDR_WIDTH: RAM write address (registered).
- `b_we` out 1: RAM write enable (registered).
- `b_wrdata` out DATA_WIDTH: RAM write data (registered).

## Operation
- **States:** INIT and RUN.
- **Registers:** sweep counter `cnt` (ADDR_WIDTH bits); round-robin pointer `prio` (0 = requester 0 preferred); `b_*` output registers.
- **Reset values:**
  - state = INIT if DO_INIT=1, else RUN.
  - `cnt` = 0, `prio` = 0, `b_we` = 0, `b_addr` = 0, `b_wrdata` = 0.
  - `init_done` = 0 if DO_INIT=1, else 1.
- **INIT:**
  - Each edge loads `b_we`=1, `b_addr`=`cnt`, `b_wrdata`=INIT_VALUE, then increments `cnt`.
  - On the edge where `cnt`==N-1: `cnt` wraps to 0, state becomes RUN, `init_done` becomes 1.
  - `w0_ready` and `w1_ready` are 0 throughout. `clear_req` is ignored; the sweep does not restart.
- **RUN, ready (combinational):**
  - If `clear_req`=1: both ready = 0.
  - Otherwise `w0_ready` = `w0_valid` & (!`w1_valid` | `prio`==0).
  - Otherwise `w1_ready` = `w1_valid` & (!`w0_valid` | `prio`==1).
  - At most one ready is high per cycle. Ready never depends on the ready signals themselves.
- **RUN, handshake on requester k (valid & ready):**
  - Next edge loads `b_we`=1, `b_addr`=wk_addr, `b_wrdata`=wk_data.
  - `prio` is set to the requester not granted (1-k).
- **RUN, no handshake:** next edge loads `b_we`=0. `b_addr`/`b_wrdata` hold. `prio` holds.
- **RUN with `clear_req`=1:** next edge sets state = INIT, `cnt` = 0, `init_done` = 0, `b_we` = 0. The sweep's first write appears one cycle later.
- **Requester rules:**
  - Requesters must hold valid/addr/data stable until ready.
  - Dropping valid before ready is permitted; no write occurs.

## Timing
- **Write latency:** handshake at edge E means the write is presented on `b_*` in the cycle after E. The RAM commits it at edge E+1.
- **Throughput:** one write per cycle.
- **Sweep length:** exactly N consecutive `b_we` cycles at addresses 0..N-1 in ascending order.
- **Out of reset with DO_INIT=1:**
  - The first sweep write is loaded at the first edge after `rstn` rises.
  - `init_done` rises on the edge that loads address N-1.
  - Requests can be accepted in that same following cycle.
- **Reset mid-operation:** asserting `rstn`=0 immediately forces all registers and outputs to their reset values, with `b_we`=0 and no clock needed. A sweep restarts from address 0 after release.
- **Fairness:** with both requesters continuously valid, grants strictly alternate. No requester waits more than one cycle behind the other.
- **Simultaneous handshake and `clear_req`:** impossible, because `clear_req` suppresses ready in the same cycle.

## Test plan
- Configure ADDR_WIDTH=4, DO_INIT=1, INIT_VALUE=0, then release reset. Required: `b_we`=1 for 16 consecutive cycles with `b_addr`=0..15 and `b_wrdata`=0. Both ready stay 0 during the sweep. `init_done` rises with the address-15 load.
- After init, hold `w0_valid`=`w1_valid`=1 with addresses 3 and 9. Required: grants go w0, w1, w0, w1… starting with w0. `b_addr` sequence is 3, 9, 3, 9, each one cycle after its handshake.
- Hold only `w1_valid`=1 for 5 cycles with addresses 1..5. Required: `w1_ready`=1 every cycle and 5 back-to-back `b_we` cycles with `b_addr`=1..5. The following write from w0 is granted immediately.
- In RUN, raise `clear_req` for one cycle with `w0_valid`=1. Required: `w0_ready`=0 that cycle, then `init_done`=0, then a 16-cycle sweep. w0 is granted only after `init_done` returns to 1.
- Assert `rstn`=0 asynchronously when `cnt`=7 during INIT. Required: `b_we` falls with no clock edge. After release, the sweep restarts at address 0 and performs 16 writes.
- Configure DO_INIT=0. Required: `init_done`=1 out of reset and no sweep writes occur. `w0_ready`=1 in the first cycle with `w0_valid`=1, and its write appears on `b_*` the next cycle.

Source files
------------

// File: rtl/ram_wr_sequencer_if.sv
// Write-side bus of ram_wr_sequencer: two valid/ready requesters in,
// registered RAM write port out.
interface ram_wr_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
);
    logic                  w0_valid;
    logic                  w0_ready;
    logic [ADDR_WIDTH-1:0] w0_addr;
    logic [DATA_WIDTH-1:0] w0_data;

    logic                  w1_valid;
    logic                  w1_ready;
    logic [ADDR_WIDTH-1:0] w1_addr;
    logic [DATA_WIDTH-1:0] w1_data;

    logic [ADDR_WIDTH-1:0] b_addr;
    logic                  b_we;
    logic [DATA_WIDTH-1:0] b_wrdata;

    // Sequencer side
    modport slave (
        input  w0_valid, w0_addr, w0_data,
        input  w1_valid, w1_addr, w1_data,
        output w0_ready, w1_ready,
        output b_addr, b_we, b_wrdata
    );

    // Requester / RAM side
    modport master (
        output w0_valid, w0_addr, w0_data,
        output w1_valid, w1_addr, w1_data,
        input  w0_ready, w1_ready,
        input  b_addr, b_we, b_wrdata
    );
endinterface

// File: rtl/ram_wr_sequencer.sv
// RAM write-port sequencer: sweeps every location with INIT_VALUE after
// reset or on clear_req, then arbitrates two requesters round-robin onto
// a registered write port.
module ram_wr_sequencer #(
    parameter int                  ADDR_WIDTH = 16,
    parameter int                  DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter bit                  DO_INIT    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear_req,
    output logic                  init_done,
    ram_wr_sequencer_if.slave     bus
);

    typedef enum logic { ST_INIT, ST_RUN } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_prio;
    logic                  r_init_done;
    logic [ADDR_WIDTH-1:0] r_b_addr;
    logic                  r_b_we;
    logic [DATA_WIDTH-1:0] r_b_wrdata;

    logic                  w_grant_ok;
    logic                  w_hs0;
    logic                  w_hs1;

    // Grants are only offered in RUN and never while a clear is pending,
    // so a handshake and a clear can never coincide.
    assign w_grant_ok   = (r_state == ST_RUN) && !clear_req;
    assign bus.w0_ready = w_grant_ok && bus.w0_valid && (!bus.w1_valid || !r_prio);
    assign bus.w1_ready = w_grant_ok && bus.w1_valid && (!bus.w0_valid ||  r_prio);
    assign w_hs0        = bus.w0_valid && bus.w0_ready;
    assign w_hs1        = bus.w1_valid && bus.w1_ready;

    assign init_done    = r_init_done;
    assign bus.b_addr   = r_b_addr;
    assign bus.b_we     = r_b_we;
    assign bus.b_wrdata = r_b_wrdata;

    // Sweep / arbitration FSM with registered write-port outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= DO_INIT ? ST_INIT : ST_RUN;
            r_init_done <= !DO_INIT;
            r_cnt       <= '0;
            r_prio      <= 1'b0;
            r_b_addr    <= '0;
            r_b_we      <= 1'b0;
            r_b_wrdata  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_b_we     <= 1'b1;
                    r_b_addr   <= r_cnt;
                    r_b_wrdata <= INIT_VALUE;
                    // Counter wraps to zero naturally after the last address.
                    r_cnt      <= r_cnt + ADDR_WIDTH'(1);
                    if (r_cnt == '1) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        r_state     <= ST_INIT;
                        r_init_done <= 1'b0;
                        r_cnt       <= '0;
                        r_b_we      <= 1'b0;
                    end else if (w_hs0) begin
                        r_b_we     <= 1'b1;
                        r_b_addr   <= bus.w0_addr;
                        r_b_wrdata <= bus.w0_data;
                        r_prio     <= 1'b1;
                    end else if (w_hs1) begin
                        r_b_we     <= 1'b1;
                        r_b_addr   <= bus.w1_addr;
                        r_b_wrdata <= bus.w1_data;
                        r_prio     <= 1'b0;
                    end else begin
                        r_b_we <= 1'b0;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_wr_sequencer.sv
// Scoreboard bench for ram_wr_sequencer: stimulus pushes expected RAM
// writes, negedge monitors pop and compare every b_we cycle.
module tb_ram_wr_sequencer;

    localparam int AW = 4;
    localparam int DW = 16;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk;
    logic rstn, rstn0;
    logic clear_req, clear0;
    logic init_done, init_done0;

    int tests = 0;
    int fails = 0;

    wr_t q[$];
    wr_t q0[$];
    wr_t e, e0;

    ram_wr_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    ram_wr_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    ram_wr_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(16'h0000), .DO_INIT(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn), .clear_req(clear_req),
        .init_done(init_done), .bus(bus.slave)
    );

    ram_wr_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(16'hFFFF), .DO_INIT(1'b0)
    ) dut0 (
        .clk(clk), .rstn(rstn0), .clear_req(clear0),
        .init_done(init_done0), .bus(bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the DO_INIT=1 instance
    always @(negedge clk) begin
        if (bus.b_we === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write at %0t",
                         bus.b_addr, bus.b_wrdata, $time);
            end else begin
                e = q.pop_front();
                chk("b_addr", 32'(bus.b_addr), 32'(e.a));
                chk("b_wrdata", 32'(bus.b_wrdata), 32'(e.d));
            end
        end
    end

    // Monitor for the DO_INIT=0 instance
    always @(negedge clk) begin
        if (bus0.b_we === 1'b1) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write0: got addr %0h data %0h, expected no write at %0t",
                         bus0.b_addr, bus0.b_wrdata, $time);
            end else begin
                e0 = q0.pop_front();
                chk("b_addr0", 32'(bus0.b_addr), 32'(e0.a));
                chk("b_wrdata0", 32'(bus0.b_wrdata), 32'(e0.d));
            end
        end
    end

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) q.push_back('{a: AW'(i), d: '0});
    endtask

    // One cycle: check ready/init_done at negedge, queue expected writes,
    // return just after the next rising edge so inputs can be changed.
    task automatic step(input logic e_r0, input logic e_r1, input logic e_done);
        @(negedge clk);
        chk("w0_ready", 32'(bus.w0_ready), 32'(e_r0));
        chk("w1_ready", 32'(bus.w1_ready), 32'(e_r1));
        chk("init_done", 32'(init_done), 32'(e_done));
        if (e_r0) q.push_back('{a: bus.w0_addr, d: bus.w0_data});
        if (e_r1) q.push_back('{a: bus.w1_addr, d: bus.w1_data});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; rstn0 = 1'b0; clear_req = 1'b0; clear0 = 1'b0;
        bus.w0_valid = 1'b1; bus.w0_addr = 4'd3; bus.w0_data = 16'hA003;
        bus.w1_valid = 1'b1; bus.w1_addr = 4'd9; bus.w1_data = 16'hB009;
        bus0.w0_valid = 1'b0; bus0.w0_addr = '0; bus0.w0_data = '0;
        bus0.w1_valid = 1'b0; bus0.w1_addr = '0; bus0.w1_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_b_we", 32'(bus.b_we), 32'd0);
        chk("rst_b_addr", 32'(bus.b_addr), 32'd0);
        chk("rst_b_wrdata", 32'(bus.b_wrdata), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_w0_ready", 32'(bus.w0_ready), 32'd0);
        chk("rst_w1_ready", 32'(bus.w1_ready), 32'd0);
        chk("rst0_init_done", 32'(init_done0), 32'd1);
        chk("rst0_b_we", 32'(bus0.b_we), 32'd0);

        // Sweep out of reset with both requesters already waiting
        @(posedge clk); #1;
        rstn = 1'b1;
        push_sweep(16);
        repeat (16) step(1'b0, 1'b0, 1'b0);

        // Both valid: strict alternation starting with w0
        for (int k = 0; k < 6; k++) step(k % 2 == 0, k % 2 == 1, 1'b1);

        // w1 alone, back-to-back, then w0 granted at once
        bus.w0_valid = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            bus.w1_addr = AW'(j);
            bus.w1_data = DW'(16'h1000 + j);
            step(1'b0, 1'b1, 1'b1);
        end
        bus.w1_valid = 1'b0;
        bus.w0_valid = 1'b1; bus.w0_addr = 4'd12; bus.w0_data = 16'hC00C;
        step(1'b1, 1'b0, 1'b1);

        // clear_req suppresses ready, then a full sweep, then w0 granted
        bus.w0_addr = 4'd5; bus.w0_data = 16'hD005;
        clear_req = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        clear_req = 1'b0;
        push_sweep(16);
        repeat (16) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        bus.w0_valid = 1'b0;
        step(1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a sweep (cnt = 7)
        clear_req = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        clear_req = 1'b0;
        push_sweep(7);
        repeat (7) step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("async_b_we", 32'(bus.b_we), 32'd0);
        chk("async_b_addr", 32'(bus.b_addr), 32'd0);
        chk("async_init_done", 32'(init_done), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        push_sweep(16);
        repeat (16) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // DO_INIT=0: no sweep, first request accepted immediately
        @(posedge clk); #1;
        rstn0 = 1'b1;
        @(negedge clk);
        chk("d0_init_done", 32'(init_done0), 32'd1);
        chk("d0_b_we_idle", 32'(bus0.b_we), 32'd0);
        @(posedge clk); #1;
        bus0.w0_valid = 1'b1; bus0.w0_addr = 4'd11; bus0.w0_data = 16'h0E0B;
        @(negedge clk);
        chk("d0_w0_ready", 32'(bus0.w0_ready), 32'd1);
        chk("d0_w1_ready", 32'(bus0.w1_ready), 32'd0);
        q0.push_back('{a: bus0.w0_addr, d: bus0.w0_data});
        @(posedge clk); #1;
        bus0.w0_valid = 1'b0;
        @(negedge clk);
        chk("d0_b_we", 32'(bus0.b_we), 32'd1);

        repeat (2) @(negedge clk);
        chk("pending_writes", 32'(q.size()), 32'd0);
        chk("pending_writes0", 32'(q0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
